// File: rtl/uart_tx_cfg_if.sv
// Push-side handshake of the configurable UART transmitter: producer valid/data,
// FIFO ready and occupancy back from the transmitter.
interface uart_tx_cfg_if #(
    parameter int MAX_DATA_WIDTH = 9,
    parameter int FIFO_DEPTH     = 16
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic                      i_vld;
    logic [MAX_DATA_WIDTH-1:0] i_data;
    logic                      o_rdy;
    logic [LW-1:0]             o_level;

    modport master (output i_vld, output i_data, input o_rdy, input o_level);
    modport slave  (input i_vld, input i_data, output o_rdy, output o_level);
endinterface

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter with push FIFO, back-to-back framing and break.
//
// state  | meaning
// IDLE   | line high, waiting for a word or a break request
// START  | start bit (tx=0)
// DATA   | data bits, LSB first
// PARITY | optional parity/mark/space bit
// STOP   | one or two stop bits (tx=1)
// BREAK  | tx held low while i_break is high
// GUARD  | tx high for two latched bit times after a break
module uart_tx_cfg #(
    parameter int MAX_DATA_WIDTH = 9,
    parameter int FIFO_DEPTH     = 16,
    parameter int DIV_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_WIDTH-1:0] cfg_div,
    input  logic [3:0]           cfg_data_bits,
    input  logic [2:0]           cfg_parity,
    input  logic                 cfg_stop2,
    input  logic                 i_break,
    uart_tx_cfg_if.slave         push,
    output logic                 tx,
    output logic                 o_busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = DIV_WIDTH + 1;
    localparam int DW = MAX_DATA_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK, S_GUARD
    } state_t;

    logic [DW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] div_sh;
    logic [3:0]    bits_left;
    logic [DW-1:0] shreg;
    logic          par_en, par_bit, stop2_sh, stop_second;

    logic [CW-1:0] div_eff;
    logic [3:0]    bits_eff;
    logic [DW-1:0] mask;
    logic [DW-1:0] head_masked;
    logic          par_en_c, par_bit_c;
    logic          frame_end, can_start, push_ok;

    assign div_eff  = (cfg_div < DIV_WIDTH'(2)) ? CW'(2) : CW'(cfg_div);
    assign bits_eff = (cfg_data_bits < 4'd5)    ? 4'd5 :
                      (cfg_data_bits > 4'(DW))  ? 4'(DW) : cfg_data_bits;

    always_comb begin
        mask = '0;
        for (int i = 0; i < DW; i++) mask[i] = (4'(i) < bits_eff);
    end

    assign head_masked = mem[rd_ptr] & mask;
    assign par_en_c    = (cfg_parity >= 3'd1) && (cfg_parity <= 3'd4);

    always_comb begin
        case (cfg_parity)
            3'd1:    par_bit_c = ~(^head_masked);
            3'd2:    par_bit_c = ^head_masked;
            3'd3:    par_bit_c = 1'b1;
            default: par_bit_c = 1'b0;
        endcase
    end

    // A frame ends on the last cycle of its final stop bit; popping here gives zero idle gap.
    assign frame_end = (state == S_STOP) && (cnt == '0) && (!stop2_sh || stop_second);
    assign can_start = ((state == S_IDLE) || frame_end) && !i_break && (level != '0);
    assign push_ok   = push.i_vld && push.o_rdy;

    assign push.o_rdy   = (level != LW'(FIFO_DEPTH));
    assign push.o_level = level;
    assign o_busy       = (state != S_IDLE) || (level != '0);

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push.i_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok)   wr_ptr <= wr_ptr + AW'(1);
            if (can_start) rd_ptr <= rd_ptr + AW'(1);
            level <= level + LW'(push_ok) - LW'(can_start);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            tx          <= 1'b1;
            cnt         <= '0;
            div_sh      <= CW'(2);
            bits_left   <= '0;
            shreg       <= '0;
            par_en      <= 1'b0;
            par_bit     <= 1'b0;
            stop2_sh    <= 1'b0;
            stop_second <= 1'b0;
        end else if (can_start) begin
            state     <= S_START;
            tx        <= 1'b0;
            cnt       <= div_eff - CW'(1);
            div_sh    <= div_eff;
            bits_left <= bits_eff;
            shreg     <= head_masked;
            par_en    <= par_en_c;
            par_bit   <= par_bit_c;
            stop2_sh  <= cfg_stop2;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_break) begin
                        state  <= S_BREAK;
                        tx     <= 1'b0;
                        div_sh <= div_eff;
                    end else begin
                        tx <= 1'b1;
                    end
                end
                S_START: begin
                    if (cnt == '0) begin
                        state <= S_DATA;
                        tx    <= shreg[0];
                        cnt   <= div_sh - CW'(1);
                    end else cnt <= cnt - CW'(1);
                end
                S_DATA: begin
                    if (cnt == '0) begin
                        cnt <= div_sh - CW'(1);
                        if (bits_left == 4'd1) begin
                            stop_second <= 1'b0;
                            if (par_en) begin
                                state <= S_PARITY;
                                tx    <= par_bit;
                            end else begin
                                state <= S_STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bits_left <= bits_left - 4'd1;
                            shreg     <= shreg >> 1;
                            tx        <= shreg[1];
                        end
                    end else cnt <= cnt - CW'(1);
                end
                S_PARITY: begin
                    if (cnt == '0) begin
                        state <= S_STOP;
                        tx    <= 1'b1;
                        cnt   <= div_sh - CW'(1);
                    end else cnt <= cnt - CW'(1);
                end
                S_STOP: begin
                    if (cnt == '0) begin
                        if (stop2_sh && !stop_second) begin
                            stop_second <= 1'b1;
                            cnt         <= div_sh - CW'(1);
                        end else if (i_break) begin
                            state <= S_BREAK;
                            tx    <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                            tx    <= 1'b1;
                        end
                    end else cnt <= cnt - CW'(1);
                end
                S_BREAK: begin
                    tx <= 1'b0;
                    if (!i_break) begin
                        state <= S_GUARD;
                        tx    <= 1'b1;
                        cnt   <= (div_sh << 1) - CW'(1);
                    end
                end
                S_GUARD: begin
                    tx <= 1'b1;
                    if (cnt == '0) state <= S_IDLE;
                    else           cnt   <= cnt - CW'(1);
                end
                default: begin
                    state <= S_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: directed scenarios plus random frames checked
// against a frame-level model that builds the expected bit list from the line rules.
module tb_uart_tx_cfg;
    localparam int DW    = 9;
    localparam int DEPTH = 16;
    localparam int DIVW  = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [DIVW-1:0] cfg_div;
    logic [3:0]      cfg_data_bits;
    logic [2:0]      cfg_parity;
    logic            cfg_stop2;
    logic            i_break;
    logic            tx;
    logic            o_busy;

    int tests = 0;
    int fails = 0;

    uart_tx_cfg_if #(.MAX_DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus ();

    uart_tx_cfg #(.MAX_DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .DIV_WIDTH(DIVW)) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_div       (cfg_div),
        .cfg_data_bits (cfg_data_bits),
        .cfg_parity    (cfg_parity),
        .cfg_stop2     (cfg_stop2),
        .i_break       (i_break),
        .push          (bus),
        .tx            (tx),
        .o_busy        (o_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input int div, input int bits, input int par, input int s2);
        cfg_div       = DIVW'(div);
        cfg_data_bits = 4'(bits);
        cfg_parity    = 3'(par);
        cfg_stop2     = 1'(s2);
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        bus.i_vld  = 1'b1;
        bus.i_data = d;
        step();
        bus.i_vld  = 1'b0;
    endtask

    // exp_wait >= 0: exact number of cycles until start; -1: only require a start.
    // skip >= 0: already sitting on frame cycle 'skip', no waiting.
    task automatic run_frame(input logic [DW-1:0] d, input int div, input int bits,
                             input int par, input int s2, input int exp_wait,
                             input int skip_in, input string tag);
        int   de, be, ones, w, total, skip;
        logic q[$];
        logic obs[$];
        bit   bad[$];
        de = (div < 2) ? 2 : div;
        be = (bits < 5) ? 5 : ((bits > DW) ? DW : bits);
        ones = 0;
        q.push_back(1'b0);
        for (int i = 0; i < be; i++) begin
            q.push_back(d[i]);
            ones += int'(d[i]);
        end
        case (par)
            1: q.push_back((ones % 2) == 0);
            2: q.push_back((ones % 2) == 1);
            3: q.push_back(1'b1);
            4: q.push_back(1'b0);
            default: ;
        endcase
        q.push_back(1'b1);
        if (s2 != 0) q.push_back(1'b1);
        for (int i = 0; i < q.size(); i++) begin
            obs.push_back(1'bx);
            bad.push_back(1'b0);
        end
        skip = skip_in;
        if (skip < 0) begin
            w = 0;
            while (tx !== 1'b0 && w < 400) begin
                step();
                w++;
            end
            if (exp_wait >= 0) chk({tag, " start_wait"}, 32'(w), 32'(exp_wait));
            else               chk({tag, " start_seen"}, 32'(tx), 32'(0));
            skip = 0;
        end
        total = q.size() * de;
        for (int t = skip; t < total; t++) begin
            if (t > skip) step();
            if (!bad[t / de]) obs[t / de] = tx;
            if (tx !== q[t / de]) bad[t / de] = 1'b1;
        end
        for (int i = skip / de; i < q.size(); i++)
            chk($sformatf("%s bit%0d", tag, i), 32'(obs[i]), 32'(q[i]));
    endtask

    logic [DW-1:0] brk_q[$];
    int            accepted;
    logic          rdy_before;
    logic          gobs;
    bit            gbad;
    int            rdiv, rbits, rpar, rs2;
    logic [DW-1:0] rdata;

    initial begin
        rst        = 1'b1;
        bus.i_vld  = 1'b0;
        bus.i_data = '0;
        i_break    = 1'b0;
        set_cfg(16, 8, 0, 0);
        repeat (3) step();
        chk("reset tx", 32'(tx), 32'(1));
        chk("reset rdy", 32'(bus.o_rdy), 32'(1));
        chk("reset busy", 32'(o_busy), 32'(0));
        chk("reset level", 32'(bus.o_level), 32'(0));
        rst = 1'b0;
        step();

        // 8N1 single frame, latency and busy fall
        push_word(9'h055);
        chk("t1 level", 32'(bus.o_level), 32'(1));
        chk("t1 busy", 32'(o_busy), 32'(1));
        run_frame(9'h055, 16, 8, 0, 0, 1, -1, "t1");
        step();
        chk("t1 idle tx", 32'(tx), 32'(1));
        chk("t1 busy fall", 32'(o_busy), 32'(0));

        // 7E2 and 7O2
        set_cfg(16, 7, 2, 1);
        push_word(9'h041);
        run_frame(9'h041, 16, 7, 2, 1, 1, -1, "t2e");
        step();
        chk("t2e busy", 32'(o_busy), 32'(0));
        set_cfg(16, 7, 1, 1);
        push_word(9'h041);
        run_frame(9'h041, 16, 7, 1, 1, 1, -1, "t2o");
        step();
        chk("t2o busy", 32'(o_busy), 32'(0));

        // three consecutive pushes, back-to-back frames
        set_cfg(16, 8, 0, 0);
        bus.i_vld = 1'b1;
        bus.i_data = 9'h001; step();
        bus.i_data = 9'h002; step();
        bus.i_data = 9'h003; step();
        bus.i_vld = 1'b0;
        chk("t3 level peak", 32'(bus.o_level), 32'(2));
        run_frame(9'h001, 16, 8, 0, 0, -1, 1, "t3a");
        run_frame(9'h002, 16, 8, 0, 0, 1, -1, "t3b");
        run_frame(9'h003, 16, 8, 0, 0, 1, -1, "t3c");
        step();
        chk("t3 busy", 32'(o_busy), 32'(0));

        // break with FIFO filling to full, then guard and drain
        i_break = 1'b1;
        step();
        chk("t4 break tx", 32'(tx), 32'(0));
        accepted = 0;
        for (int k = 0; k < 17; k++) begin
            bus.i_vld  = 1'b1;
            bus.i_data = DW'($urandom);
            rdy_before = bus.o_rdy;
            if (rdy_before) brk_q.push_back(bus.i_data);
            step();
            if (rdy_before) accepted++;
        end
        bus.i_vld = 1'b0;
        chk("t4 accepted", 32'(accepted), 32'(16));
        chk("t4 rdy full", 32'(bus.o_rdy), 32'(0));
        chk("t4 level full", 32'(bus.o_level), 32'(16));
        chk("t4 tx held", 32'(tx), 32'(0));
        chk("t4 busy", 32'(o_busy), 32'(1));
        i_break = 1'b0;
        step();
        gbad = 1'b0;
        gobs = tx;
        for (int g = 0; g < 32; g++) begin
            if (g > 0) step();
            if (!gbad) gobs = tx;
            if (tx !== 1'b1) gbad = 1'b1;
        end
        chk("t4 guard high", 32'(gobs), 32'(1));
        for (int k = 0; k < brk_q.size(); k++)
            run_frame(brk_q[k], 16, 8, 0, 0, (k == 0) ? -1 : 1, -1, $sformatf("t4 drain%0d", k));
        step();
        chk("t4 busy end", 32'(o_busy), 32'(0));

        // reset during data bit 3
        push_word(9'h0A5);
        push_word(9'h03C);
        repeat (4 * 16 + 8) step();
        chk("t5 mid bit3", 32'(tx), 32'(0));
        chk("t5 level pre", 32'(bus.o_level), 32'(1));
        rst = 1'b1;
        step();
        chk("t5 tx", 32'(tx), 32'(1));
        chk("t5 level", 32'(bus.o_level), 32'(0));
        chk("t5 rdy", 32'(bus.o_rdy), 32'(1));
        chk("t5 busy", 32'(o_busy), 32'(0));
        rst = 1'b0;
        step();
        push_word(9'h096);
        run_frame(9'h096, 16, 8, 0, 0, 1, -1, "t5 fresh");
        step();

        // divisor change mid-frame, then div=0
        push_word(9'h0C3);
        push_word(9'h05A);
        cfg_div = DIVW'(32);
        run_frame(9'h0C3, 16, 8, 0, 0, 0, -1, "t6 div16");
        run_frame(9'h05A, 32, 8, 0, 0, 1, -1, "t6 div32");
        step();
        chk("t6 busy", 32'(o_busy), 32'(0));
        cfg_div = '0;
        push_word(9'h00F);
        run_frame(9'h00F, 0, 8, 0, 0, 1, -1, "t6 div0");
        step();

        // random configurations
        for (int r = 0; r < 10; r++) begin
            rdiv  = int'($urandom_range(0, 5));
            rbits = int'($urandom_range(3, 12));
            rpar  = int'($urandom_range(0, 7));
            rs2   = int'($urandom_range(0, 1));
            rdata = DW'($urandom);
            set_cfg(rdiv, rbits, rpar, rs2);
            push_word(rdata);
            run_frame(rdata, rdiv, rbits, rpar, rs2, 1, -1, $sformatf("rnd%0d", r));
            step();
            chk($sformatf("rnd%0d busy", r), 32'(o_busy), 32'(0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Runtime-configurable UART transmitter with an internal transmit FIFO and break generation. It is the successor to the fixed-parameter UART TX. Baud divisor, data width, parity mode and stop-bit count are run-time inputs instead of elaboration-time constants. A push-side valid/ready FIFO decouples the producer, and frames are sent back-to-back with no idle gap. The block sits between a CPU/register bank or DMA source and the serial pin.

## Interface
- MAX_DATA_WIDTH, 9: widest supported character, legal range 5..9.
- FIFO_DEPTH, 16: TX FIFO entries. Must be a power of two and at least 2.
- DIV_WIDTH, 16: width of the baud divisor input.
- clk  in  1  clock. Reset is rst, synchronous, active-high; clock is clk.
- rst  in  1  synchronous active-high reset.
- cfg_div  in  DIV_WIDTH  clk cycles per bit. Values 0 and 1 are treated as 2.
- cfg_data_bits  in  4  character length. Values below 5 are treated as 5; values above MAX_DATA_WIDTH are treated as MAX_DATA_WIDTH.
- cfg_parity  in  3  parity mode: 0 none, 1 odd, 2 even, 3 mark (1), 4 space (0), 5..7 none.
- cfg_stop2  in  1  0 = one stop bit, 1 = two stop bits.
- i_break  in  1  request a break condition on the line.
- i_vld  in  1  push request.
- i_data  in  MAX_DATA_WIDTH  character to send. Bits at or above cfg_data_bits are ignored.
- o_rdy  out  1  FIFO not full.
- tx  out  1  serial line, idle high.
- o_busy  out  1  a frame, break, or post-break guard is in progress, or the FIFO is non-empty.
- o_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

## Operation
- Push: a word is accepted on any edge where i_vld && o_rdy.
- o_rdy = (o_level != FIFO_DEPTH).
- The FIFO has no drop and no overwrite; a push while full is impossible because o_rdy is low.
- States: IDLE, START, DATA, PARITY, STOP, BREAK, GUARD.
- IDLE, with FIFO non-empty and i_break low:
  - pop one word;
  - latch cfg_div, cfg_data_bits, cfg_parity and cfg_stop2 into shadow registers;
  - go to START.
  - Config changes mid-frame have no effect until the next frame.
- START: tx=0 for div cycles.
- DATA: data bits are sent LSB first, each held for div cycles.
- PARITY: present only when the mode is not "none".
  - odd: the bit makes the total count of ones in the masked data plus parity odd.
  - even: the bit makes that count even.
  - mark: 1. space: 0.
- STOP: tx=1 for 1 or 2 bit times.
- Back-to-back frames: on the final cycle of the last stop bit, if the FIFO is non-empty and i_break is low, pop immediately. The next START begins on the following cycle with zero idle cycles.
- Frame length is exactly div × (1 + bits + p + stop) cycles, where p is 0 or 1 and stop is 1 or 2.
- Break:
  - i_break is sampled only in IDLE or at a frame end; a frame in progress always completes.
  - BREAK drives tx=0 for as long as i_break is high. The FIFO is not popped.
  - When i_break falls, GUARD drives tx=1 for 2 × div cycles (latched div), then the block returns to IDLE.
- Arithmetic:
  - The bit counter counts from div−1 down to 0; a bit ends at count 0.
  - o_level is incremented on push and decremented on pop. A simultaneous push and pop leaves it unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values: tx=1, o_rdy=1, o_busy=0, o_level=0, state IDLE.
  - The FIFO is flushed.
  - A reset mid-frame takes tx high on the next edge and aborts the frame; no partial frame resumes.
- Latency, empty FIFO in IDLE: word accepted at edge N → o_level=1 after edge N → popped at edge N+1 → tx=0 after edge N+1.
- tx is registered, with no combinational path from inputs to tx.
- o_rdy and o_level are registered and reflect pushes and pops of the previous edge.
- A push on the same edge as a pop while full is not possible (o_rdy=0). A push on the same edge as a pop when level is 1 leaves level at 1.
- o_busy falls in the cycle after the last stop bit (or GUARD) completes with the FIFO empty.

## Test plan
1. div=16, 8N1 (data_bits=8, parity=0, stop2=0), push 0x55 → tx after start: 0,1,0,1,0,1,0,1,0,1, each 16 cycles; 160 cycles total; o_busy then falls.
2. div=16, 7E2, push 0x41 → tx: 0, 1,0,0,0,0,0,1, parity 0, 1, 1; 176 cycles. Repeat with odd parity → parity bit is 1.
3. div=16, 8N1, push 0x01, 0x02, 0x03 on consecutive cycles → three frames with no idle high between them; 480 cycles from first start to last stop end; o_level peaks at 2.
4. i_break high, then push 17 words with FIFO_DEPTH=16 → 16 accepted, o_rdy=0 on the 17th, tx held 0. Release break → tx=1 for 32 cycles, then frames drain.
5. Reset asserted in the middle of data bit 3 → after the next edge: tx=1, o_level=0, o_rdy=1, o_busy=0; the following push starts a fresh frame.
6. Change cfg_div from 16 to 32 mid-frame → the current frame keeps 16 cycles per bit; the next frame uses 32. cfg_div=0 → bits last 2 cycles.
